bus_dma: RTL
============

Name: bus_dma

Overview:
- Bus initiator (DMA engine) on the word-addressed memory bus: 30-bit word address, 32-bit registered read data with 1-cycle latency, 32-bit write data, 4-bit byte write mask.
- Supports two modes: copy a block of words from src to dst, or fill a block with a constant under a byte mask.
- Shares the memory responder with the CPU through an external req/grant mux; the engine only advances in granted cycles.
- Used for memory init/clear and block moves without CPU involvement.

Parameters:
LEN_W, 16, width of word-count input; max transfer 2^LEN_W-1 words

Ports:
clock       input   1       system clock; all state changes on posedge
reset       input   1       synchronous, active-high reset
start       input   1       1-cycle request; sampled only in SIdle
mode        input   1       0 = copy, 1 = fill; latched at start
src_addr    input   30      copy source word address; latched at start
dst_addr    input   30      destination word address; latched at start
length      input   LEN_W   word count; latched at start
fill_data   input   32      fill pattern; latched at start
fill_mask   input   4       byte mask for fill writes; latched at start
busy        output  1       high from cycle after accepted start until done cycle inclusive
done        output  1       1-cycle pulse at end of transfer
bus_req     output  1       high in SRead/SWrite
bus_grant   input   1       arbiter grant; engine advances only when 1
bus_addr    output  30      word address
bus_data_r  input   32      read data; valid the cycle after the address was presented
bus_data_w  output  32      write data
bus_mask_w  output  4       byte write enables; commit at posedge when nonzero

Behaviour:
- Reset: state=SIdle; busy=0, done=0, bus_req=0, bus_mask_w=0, bus_addr=0, bus_data_w=0; rd_pend=0.
- States: SIdle, SRead, SWrite, SDone.
- SIdle: start=1 latches all inputs. Counter cnt<=length.
  - length=0 -> SDone.
  - mode=1 -> SWrite.
  - mode=0 -> SRead.
  - start in any other state is ignored.
- SRead: bus_addr=src, mask=0, bus_req=1.
  - If grant: src<=src+1, rd_pend<=1, -> SWrite.
  - Else hold.
- rd_pend is set for exactly the cycle after a granted read; in that cycle buf<=bus_data_r.
- SWrite: bus_addr=dst, bus_req=1.
  - Copy: bus_data_w = rd_pend ? bus_data_r : buf.
  - Fill: bus_data_w = fill_data.
  - Copy mask = grant ? 4'b1111 : 0. Fill mask = grant ? fill_mask : 0.
  - If grant: dst<=dst+1, cnt<=cnt-1. If cnt==1 -> SDone; else copy -> SRead, fill stays SWrite.
- bus_mask_w is nonzero only when state==SWrite && grant. It is combinational from registered state and grant.
- Throughput with continuous grant: copy 2 cycles/word, fill 1 cycle/word.
- SDone: done=1, busy=1, bus_req=0; next cycle -> SIdle. A start presented in the SDone cycle is ignored.
- Addresses increment modulo 2^30; wrap from 0x3FFFFFFF to 0 is required and silent.
- Copy is ascending and word-serial: each word is read before it is written. With overlapping ranges, dst<=src gives a correct move; dst>src replicates data (defined, not an error).
- Grant dropped in the cycle after a read: data is preserved in buf; the write proceeds when grant returns.
- Reset mid-transfer: the next cycle is SIdle with mask=0. A partially written destination is permitted. No done pulse.
- Read issued in SWrite: the responder also returns data from dst. This data is ignored.

Decomposition:
- Shared package bus_pkg:
  - typedef addr_t (logic[29:0]), data_t (logic[31:0]), mask_t (logic[3:0])
  - constant MASK_WORD = 4'b1111
- dma_state_t enum is local to the module.
- Single flat module; no sub-module. Bench pairs it with the existing block RAM model.

Test Plan:
- Copy: RAM[0x10..0x13]={A0,A1,A2,A3}, start src=0x10 dst=0x40 len=4, grant=1 -> RAM[0x40..0x43] matches; done pulses 9 cycles after start; busy high 9 cycles.
- Fill: start mode=1 dst=0x80 len=3 data=0xDEADBEEF mask=4'b0011, RAM pre=0x11111111 -> words become 0x1111BEEF; done 4 cycles after start.
- Zero length: len=0 -> no cycle with mask!=0; done pulses exactly 1 cycle after accepted start.
- Grant stall: copy len=2; drop grant for 3 cycles immediately after the first granted read -> no write while grant=0; dst word still equals source (buf path).
- Wrap: fill dst=0x3FFFFFFF len=2 -> writes to 0x3FFFFFFF then 0x00000000.
- Reset mid-copy (after 1st word written, len=4) -> mask=0 and busy=0 the cycle after reset; no done; only the first dst word changed; a new start is then accepted normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared memory-bus types: word address, data word and byte write mask.
package bus_pkg;

    typedef logic [29:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  mask_t;

    localparam mask_t MASK_WORD = 4'b1111;

endpackage

// File: rtl/bus_dma_if.sv
// Word-addressed memory bus between an initiator and the shared responder/arbiter.
interface bus_dma_if;
    import bus_pkg::*;

    logic  bus_req;
    logic  bus_grant;
    addr_t bus_addr;
    data_t bus_data_r;
    data_t bus_data_w;
    mask_t bus_mask_w;

    modport master (
        output bus_req, bus_addr, bus_data_w, bus_mask_w,
        input  bus_grant, bus_data_r
    );

    modport slave (
        input  bus_req, bus_addr, bus_data_w, bus_mask_w,
        output bus_grant, bus_data_r
    );

endinterface

// File: rtl/bus_dma.sv
// DMA engine: block copy (src -> dst) or masked constant fill, advancing only on granted cycles.
module bus_dma
    import bus_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  addr_t            src_addr,
    input  addr_t            dst_addr,
    input  logic [LEN_W-1:0] length,
    input  data_t            fill_data,
    input  mask_t            fill_mask,
    output logic             busy,
    output logic             done,
    bus_dma_if.master        bus
);

    typedef enum logic [1:0] {SIdle, SRead, SWrite, SDone} dma_state_t;

    dma_state_t       state_q, state_d;
    logic             mode_q, mode_d;
    addr_t            src_q, src_d;
    addr_t            dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    data_t            fill_data_q, fill_data_d;
    mask_t            fill_mask_q, fill_mask_d;
    logic             rd_pend_q, rd_pend_d;
    data_t            buf_q, buf_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SIdle;
            mode_q      <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            fill_data_q <= '0;
            fill_mask_q <= '0;
            rd_pend_q   <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            fill_data_q <= fill_data_d;
            fill_mask_q <= fill_mask_d;
            rd_pend_q   <= rd_pend_d;
            buf_q       <= buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        fill_data_d = fill_data_q;
        fill_mask_d = fill_mask_q;
        rd_pend_d   = 1'b0;
        // Read data is only valid the cycle after a granted read; hold it across grant stalls.
        buf_d       = rd_pend_q ? bus.bus_data_r : buf_q;

        busy           = 1'b0;
        done           = 1'b0;
        bus.bus_req    = 1'b0;
        bus.bus_addr   = '0;
        bus.bus_data_w = '0;
        bus.bus_mask_w = '0;

        case (state_q)
            SIdle: begin
                if (start) begin
                    mode_d      = mode;
                    src_d       = src_addr;
                    dst_d       = dst_addr;
                    cnt_d       = length;
                    fill_data_d = fill_data;
                    fill_mask_d = fill_mask;
                    if (length == '0) begin
                        state_d = SDone;
                    end else if (mode) begin
                        state_d = SWrite;
                    end else begin
                        state_d = SRead;
                    end
                end
            end
            SRead: begin
                busy         = 1'b1;
                bus.bus_req  = 1'b1;
                bus.bus_addr = src_q;
                if (bus.bus_grant) begin
                    src_d     = src_q + 30'd1;
                    rd_pend_d = 1'b1;
                    state_d   = SWrite;
                end
            end
            SWrite: begin
                busy           = 1'b1;
                bus.bus_req    = 1'b1;
                bus.bus_addr   = dst_q;
                bus.bus_data_w = mode_q ? fill_data_q : (rd_pend_q ? bus.bus_data_r : buf_q);
                if (bus.bus_grant) begin
                    bus.bus_mask_w = mode_q ? fill_mask_q : MASK_WORD;
                    dst_d          = dst_q + 30'd1;
                    cnt_d          = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = SDone;
                    end else if (!mode_q) begin
                        state_d = SRead;
                    end
                end
            end
            SDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = SIdle;
            end
            default: state_d = SIdle;
        endcase
    end

endmodule
